riscv_alu_arbiter: RTL and testbench

- Shares one combinational riscv_alu instance between NREQ requesters, e.g. the execute stage and the branch/address-generation unit.
- Each requester uses a valid/ready request channel. Requests are granted round-robin.
- The ALU result is registered into a single-entry response buffer, tagged with the requester id, and returned on one shared valid/ready response channel.

---
 rtl/riscv_alu_pkg.sv | 51 +++++
 rtl/riscv_alu.sv | 35 +++
 rtl/riscv_alu_arbiter.sv | 109 ++++++++++
 tb/tb_riscv_alu_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared ALU opcode encodings and arbitration helpers
// for riscv_alu and riscv_alu_arbiter.
package riscv_alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD   = 4'd0;
  localparam alu_op_t OP_SUB   = 4'd1;
  localparam alu_op_t OP_ONE   = 4'd2;
  localparam alu_op_t OP_ZERO  = 4'd3;
  localparam alu_op_t OP_XOR   = 4'd4;
  localparam alu_op_t OP_OR    = 4'd5;
  localparam alu_op_t OP_AND   = 4'd6;
  localparam alu_op_t OP_SLL   = 4'd7;
  localparam alu_op_t OP_SRL   = 4'd8;
  localparam alu_op_t OP_SRA   = 4'd9;
  localparam alu_op_t OP_PASSB = 4'd10;

  localparam int unsigned MAXREQ = 8;

  function automatic logic op_illegal(
    input alu_op_t op
  );
    return op > OP_PASSB;
  endfunction

  // One-hot grant: first valid index at or after ptr,
  // wrapping modulo n (n <= MAXREQ).
  function automatic logic [MAXREQ-1:0] rr_grant(
    input logic [MAXREQ-1:0] valid,
    input logic [2:0]        ptr,
    input int unsigned       n
  );
    logic [MAXREQ-1:0] g;
    logic              found;
    int unsigned       idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAXREQ; i++) begin
      if (i < n) begin
        idx = ({29'd0, ptr} + i) % n;
        if (!found && valid[idx[2:0]]) begin
          g[idx[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32 ALU; illegal opcodes yield 0
// with o_err asserted.
module riscv_alu
  import riscv_alu_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_err
);

  logic [4:0] w_sh;
  assign w_sh  = i_b[4:0];
  assign o_err = op_illegal(i_op);

  always_comb begin
    o_result = 32'd0;
    case (i_op)
      OP_ADD:   o_result = i_a + i_b;
      OP_SUB:   o_result = i_a - i_b;
      OP_ONE:   o_result = 32'd1;
      OP_ZERO:  o_result = 32'd0;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_AND:   o_result = i_a & i_b;
      OP_SLL:   o_result = i_a << w_sh;
      OP_SRL:   o_result = i_a >> w_sh;
      OP_SRA:   o_result = $signed(i_a) >>> w_sh;
      OP_PASSB: o_result = i_b;
      default:  o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Round-robin sharing of one riscv_alu between NREQ
// requesters, with a single registered response slot.
module riscv_alu_arbiter
  import riscv_alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*4-1:0] req_op_i,
  input  logic [NREQ*32-1:0] req_a_i,
  input  logic [NREQ*32-1:0] req_b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [31:0]       rsp_result_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic              r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [31:0]       r_result;
  logic              r_err;

  logic              w_accept;
  logic [MAXREQ-1:0] w_valid8;
  logic [2:0]        w_ptr8;
  logic [MAXREQ-1:0] w_gnt8;
  logic              w_gnt;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_ptr_nxt;
  alu_op_t           w_op;
  logic [31:0]       w_a;
  logic [31:0]       w_b;
  logic [31:0]       w_res;
  logic              w_err;

  assign w_accept = (r_state == ST_EMPTY) || rsp_ready_i;

  always_comb begin
    w_valid8 = '0;
    w_valid8[NREQ-1:0] = req_valid_i;
    w_ptr8 = '0;
    w_ptr8[IDW-1:0] = r_ptr;
  end

  assign w_gnt8 = (w_accept && rst_ni)
                ? rr_grant(w_valid8, w_ptr8, NREQ)
                : '0;
  assign w_gnt  = |w_gnt8;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt8[k]) w_idx = IDW'(k);
    end
  end

  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1))
                   ? '0 : w_idx + 1'b1;

  assign w_op = req_op_i[4*w_idx +: 4];
  assign w_a  = req_a_i[32*w_idx +: 32];
  assign w_b  = req_b_i[32*w_idx +: 32];

  riscv_alu u_alu (
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_res),
    .o_err    (w_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_EMPTY;
      r_ptr    <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_state  <= ST_FULL;
        r_ptr    <= w_ptr_nxt;
        r_id     <= w_idx;
        r_result <= w_res;
        r_err    <= w_err;
      end else if (rsp_ready_i) begin
        r_state  <= ST_EMPTY;
      end
    end
  end

  assign req_ready_o  = w_gnt8[NREQ-1:0];
  assign rsp_valid_o  = r_state;
  assign rsp_id_o     = r_id;
  assign rsp_result_o = r_result;
  assign rsp_err_o    = r_err;
  assign busy_o       = r_state | (|req_valid_i);

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed self-checking bench for riscv_alu_arbiter
// with two requesters.
module tb_riscv_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [7:0]  req_op_i;
  logic [63:0] req_a_i;
  logic [63:0] req_b_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [0:0]  rsp_id_o;
  logic [31:0] rsp_result_o;
  logic        rsp_err_o;
  logic        busy_o;

  int tests  = 0;
  int failed = 0;

  riscv_alu_arbiter #(.NREQ(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k,
                         input logic v,
                         input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    req_valid_i[k]       = v;
    req_op_i[4*k +: 4]   = op;
    req_a_i[32*k +: 32]  = a;
    req_b_i[32*k +: 32]  = b;
  endtask

  task automatic chk_rsp(input string tag,
                         input logic v,
                         input logic id,
                         input logic [31:0] res,
                         input logic err);
    chk({tag, "_valid"}, {31'd0, rsp_valid_o}, {31'd0, v});
    chk({tag, "_id"}, {31'd0, rsp_id_o}, {31'd0, id});
    chk({tag, "_res"}, rsp_result_o, res);
    chk({tag, "_err"}, {31'd0, rsp_err_o}, {31'd0, err});
  endtask

  logic [3:0]  ops [10];
  logic [31:0] exps[10];

  initial begin
    ops[0] = 4'd0;  exps[0] = 32'h80000034;
    ops[1] = 4'd1;  exps[1] = 32'h7FFFFFEC;
    ops[2] = 4'd7;  exps[2] = 32'h00000100;
    ops[3] = 4'd8;  exps[3] = 32'h08000001;
    ops[4] = 4'd9;  exps[4] = 32'hF8000001;
    ops[5] = 4'd10; exps[5] = 32'h00000024;
    ops[6] = 4'd2;  exps[6] = 32'h00000001;
    ops[7] = 4'd3;  exps[7] = 32'h00000000;
    ops[8] = 4'd4;  exps[8] = 32'h80000034;
    ops[9] = 4'd6;  exps[9] = 32'h00000000;

    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b0;
    tick();
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    tick();
    chk_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_ready", {30'd0, req_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd1);

    // test 1: reset while a response is pending
    rst_ni = 1'b1;
    #1;
    chk("t1_ready", {30'd0, req_ready_o}, 32'd1);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd5, 32'd7);
    chk_rsp("t1_add", 1'b1, 1'b0, 32'd12, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("t1_async", {31'd0, rsp_valid_o}, 32'd0);
    #1 rst_ni = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
    set_req(1, 1'b1, 4'd0, 32'd3, 32'd4);
    #1;
    chk("t1_ptr0", {30'd0, req_ready_o}, 32'd1);
    tick();
    chk_rsp("t1_first", 1'b1, 1'b0, 32'd3, 1'b0);
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    tick();
    chk("t1_drain", {31'd0, rsp_valid_o}, 32'd0);
    chk("t1_idle", {31'd0, busy_o}, 32'd0);

    // test 2: every opcode from requester 0, back to back
    for (int i = 0; i < 10; i++) begin
      set_req(0, 1'b1, ops[i], 32'h80000010, 32'h00000024);
      tick();
      chk_rsp($sformatf("t2_op%0d", ops[i]),
              1'b1, 1'b0, exps[i], 1'b0);
    end
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("t2_drain", {31'd0, rsp_valid_o}, 32'd0);

    // pointer is 1; one grant to requester 1 returns it to 0
    set_req(1, 1'b1, 4'd10, 32'd0, 32'd99);
    tick();
    chk_rsp("t3_pre", 1'b1, 1'b1, 32'd99, 1'b0);

    // test 3: both valid, full throughput rotation
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    set_req(1, 1'b1, 4'd0, 32'd10, 32'd10);
    tick();
    chk_rsp("t3_g0", 1'b1, 1'b0, 32'd2, 1'b0);
    tick();
    chk_rsp("t3_g1", 1'b1, 1'b1, 32'd20, 1'b0);
    tick();
    chk_rsp("t3_g2", 1'b1, 1'b0, 32'd2, 1'b0);
    tick();
    chk_rsp("t3_g3", 1'b1, 1'b1, 32'd20, 1'b0);

    // test 4: backpressure holds the buffer
    rsp_ready_i = 1'b0;
    #1;
    chk("t4_noready", {30'd0, req_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp($sformatf("t4_hold%0d", i),
              1'b1, 1'b1, 32'd20, 1'b0);
      chk($sformatf("t4_rdy%0d", i),
          {30'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("t4_next", {30'd0, req_ready_o}, 32'd1);
    tick();
    chk_rsp("t4_g", 1'b1, 1'b0, 32'd2, 1'b0);
    req_valid_i = '0;
    tick();
    chk("t4_drain", {31'd0, rsp_valid_o}, 32'd0);

    // test 5: illegal opcode from requester 1
    set_req(1, 1'b1, 4'hC, 32'hFFFFFFFF, 32'h1);
    tick();
    chk_rsp("t5_ill", 1'b1, 1'b1, 32'd0, 1'b1);
    req_valid_i = 2'b11;
    #1;
    chk("t5_ptr", {30'd0, req_ready_o}, 32'd1);
    tick();
    req_valid_i = '0;
    tick();
    chk("t5_drain", {31'd0, rsp_valid_o}, 32'd0);

    // test 6: shift amount uses b[4:0] only
    set_req(0, 1'b1, 4'd7, 32'd1, 32'h00000021);
    tick();
    chk_rsp("t6_sll", 1'b1, 1'b0, 32'd2, 1'b0);
    req_valid_i = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
